// File: rtl/ten_thirty_game_pkg.sv
// ten_thirty_game_pkg: FSM states, 7-seg patterns, LED result codes and card/digit helpers
package ten_thirty_game_pkg;
  typedef enum logic [1:0] {IDLE, PLAYER, DEALER, RESULT} state_t;
  localparam logic [3:0] SEG_BLANK = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [9:0][6:0] SEG_DIGITS = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [2:0] LED_PLAYER = 3'b001;
  localparam logic [2:0] LED_DEALER = 3'b010;
  localparam logic [2:0] LED_DRAW = 3'b100;
  function automatic logic [3:0] card_rank(input logic [3:0] n);
    return n == 4'd0 ? 4'd13 : n == 4'd14 ? 4'd1 : n == 4'd15 ? 4'd2 : n;
  endfunction
  function automatic logic [5:0] card_value(input logic [3:0] r);
    return r <= 4'd10 ? {1'b0, r, 1'b0} : 6'd1;
  endfunction
  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [3:0] t;
    t = v >= 5'd30 ? 4'd3 : v >= 5'd20 ? 4'd2 : v >= 5'd10 ? 4'd1 : 4'd0;
    return {t, 4'(v - 5'(t) * 5'd10)};
  endfunction
  function automatic logic [4:0] tens_code(input logic [7:0] b);
    return {1'b0, b[7:4] == 4'd0 ? SEG_BLANK : b[7:4]};
  endfunction
endpackage

// File: rtl/ten_thirty_seg_decoder.sv
// ten_thirty_seg_decoder: digit (15 = blank) + dp -> {dp,g,f,e,d,c,b,a} pattern
module ten_thirty_seg_decoder import ten_thirty_game_pkg::*; (
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] pattern
);
  assign pattern = {dp, digit < 4'd10 ? SEG_DIGITS[digit] : SEG_OFF};
endmodule

// File: rtl/ten_thirty_game.sv
// ten_thirty_game: ten-and-a-half game (clk, rst_n async active-high, btn_m draw, btn_r stand -> seg7_sel/seg7/seg7_l scan, led result)
module ten_thirty_game import ten_thirty_game_pkg::*; #(
  parameter int         DIV_BIT      = 5,
  parameter int         SCAN_BIT     = 2,
  parameter logic [7:0] LFSR_SEED    = 8'h5A,
  parameter logic [5:0] DEALER_STAND = 6'd14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_m,
  input  logic       btn_r,
  output logic [7:0] seg7_sel,
  output logic [7:0] seg7,
  output logic [7:0] seg7_l,
  output logic [2:0] led
);
  logic [24:0] counter;
  logic [7:0] lfsr, lfsr_n, pt, pc, dt, dc, pat_lo, pat_hi;
  state_t state, state_n;
  logic [5:0] p_tot, p_tot_n, d_tot, d_tot_n, val, p_sum, d_sum;
  logic [3:0] p_card, p_card_n, d_card, d_card_n, rank;
  logic [2:0] led_n;
  logic p_show, p_show_n, d_show, d_show_n, m_q, r_q, tick, press_m, press_r, draw;
  logic [1:0] s;
  logic [7:0][4:0] dig;
  assign tick = counter[DIV_BIT] & ~|counter[DIV_BIT-1:0];
  assign press_m = tick & btn_m & ~m_q;
  assign press_r = tick & btn_r & ~r_q & ~press_m;
  assign rank = card_rank(lfsr[3:0]);
  assign val = card_value(rank);
  assign p_sum = p_tot + val;
  assign d_sum = d_tot + val;
  assign lfsr_n = draw ? {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]} : lfsr;
  always_comb begin
    state_n = state;
    p_tot_n = p_tot;
    d_tot_n = d_tot;
    p_card_n = p_card;
    d_card_n = d_card;
    led_n = led;
    p_show_n = p_show;
    d_show_n = d_show;
    draw = 1'b0;
    case (state)
      IDLE: if (press_m) begin
        state_n = PLAYER;
        p_tot_n = val;
        p_card_n = rank;
        d_tot_n = '0;
        d_card_n = '0;
        led_n = '0;
        p_show_n = 1'b1;
        d_show_n = 1'b0;
        draw = 1'b1;
      end
      PLAYER: if (press_m) begin
        p_tot_n = p_sum;
        p_card_n = rank;
        draw = 1'b1;
        state_n = p_sum > 6'd21 ? RESULT : PLAYER;
        led_n = p_sum > 6'd21 ? LED_DEALER : led;
      end else if (press_r) state_n = DEALER;
      DEALER: if (tick) begin
        if (d_tot < DEALER_STAND) begin
          d_tot_n = d_sum;
          d_card_n = rank;
          d_show_n = 1'b1;
          draw = 1'b1;
          state_n = d_sum > 6'd21 ? RESULT : DEALER;
          led_n = d_sum > 6'd21 ? LED_PLAYER : led;
        end else begin
          state_n = RESULT;
          led_n = p_tot > d_tot ? LED_PLAYER : p_tot < d_tot ? LED_DEALER : LED_DRAW;
        end
      end
      RESULT: if (press_m | press_r) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign s = counter[SCAN_BIT+1:SCAN_BIT];
  assign pt = to_bcd(p_tot[5:1]);
  assign dt = to_bcd(d_tot[5:1]);
  assign pc = to_bcd({1'b0, p_card});
  assign dc = to_bcd({1'b0, d_card});
  assign dig = {
    d_show ? {1'b0, dc[3:0]} : {1'b0, SEG_BLANK},
    d_show ? tens_code(dc) : {1'b0, SEG_BLANK},
    d_show ? {d_tot[0], dt[3:0]} : {1'b0, SEG_BLANK},
    d_show ? tens_code(dt) : {1'b0, SEG_BLANK},
    p_show ? {1'b0, pc[3:0]} : {1'b0, SEG_BLANK},
    p_show ? tens_code(pc) : {1'b0, SEG_BLANK},
    p_show ? {p_tot[0], pt[3:0]} : {1'b0, SEG_BLANK},
    p_show ? tens_code(pt) : {1'b0, SEG_BLANK}
  };
  ten_thirty_seg_decoder u_dec_lo (.digit(dig[{1'b0, s}][3:0]), .dp(dig[{1'b0, s}][4]), .pattern(pat_lo));
  ten_thirty_seg_decoder u_dec_hi (.digit(dig[{1'b1, s}][3:0]), .dp(dig[{1'b1, s}][4]), .pattern(pat_hi));
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      counter <= '0;
      lfsr <= LFSR_SEED;
      state <= IDLE;
      p_tot <= '0;
      d_tot <= '0;
      p_card <= '0;
      d_card <= '0;
      led <= '0;
      p_show <= 1'b0;
      d_show <= 1'b0;
      m_q <= 1'b0;
      r_q <= 1'b0;
      seg7_sel <= 8'h11;
      seg7 <= '0;
      seg7_l <= '0;
    end else begin
      counter <= counter + 25'd1;
      lfsr <= lfsr_n;
      state <= state_n;
      p_tot <= p_tot_n;
      d_tot <= d_tot_n;
      p_card <= p_card_n;
      d_card <= d_card_n;
      led <= led_n;
      p_show <= p_show_n;
      d_show <= d_show_n;
      m_q <= tick ? btn_m : m_q;
      r_q <= tick ? btn_r : r_q;
      seg7_sel <= 8'h11 << s;
      seg7 <= pat_lo;
      seg7_l <= pat_hi;
    end
  end
endmodule

// File: tb/tb_ten_thirty_game.sv
// tb_ten_thirty_game: scoreboarded directed games checking display frames, LEDs and scan order
module tb_ten_thirty_game;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_m = 1'b0;
  logic btn_r = 1'b0;
  logic [7:0] seg7_sel, seg7, seg7_l;
  logic [2:0] led;
  int vectors = 0;
  int miscompares = 0;
  logic [66:0] exp_q[$];
  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [7:0] SCAN_SEQ [4] = '{8'h44, 8'h88, 8'h11, 8'h22};
  ten_thirty_game dut (
    .clk(clk), .rst_n(rst_n), .btn_m(btn_m), .btn_r(btn_r),
    .seg7_sel(seg7_sel), .seg7(seg7), .seg7_l(seg7_l), .led(led)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [66:0] mk(input string s, input logic [2:0] l);
    logic [63:0] d;
    int k;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] != " ") begin
        k = int'(s[i]) - 48;
        d[i*8 +: 8] = {1'b0, SEG[k]};
      end
    end
    return {d, l};
  endfunction
  task automatic expect_frame(input string s, input logic [2:0] l);
    exp_q.push_back(mk(s, l));
  endtask
  task automatic press(input logic m, input logic r, input int ticks);
    btn_m = m;
    btn_r = r;
    repeat (64 * ticks) @(negedge clk);
    btn_m = 1'b0;
    btn_r = 1'b0;
    repeat (64) @(negedge clk);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 67'(exp_q.size()), 67'd0);
  endtask
  initial begin : monitor
    logic [63:0] cur;
    logic [66:0] last, frame;
    logic [2:0] led_q;
    int idx, pidx;
    cur = '0;
    last = '0;
    led_q = '0;
    pidx = 0;
    forever begin
      @(negedge clk);
      if (rst_n) pidx = 0;
      else begin
        idx = seg7_sel == 8'h11 ? 0 : seg7_sel == 8'h22 ? 1 : seg7_sel == 8'h44 ? 2 : seg7_sel == 8'h88 ? 3 : -1;
        if (idx < 0) check("scan_onehot", {59'd0, seg7_sel}, 67'h11);
        else begin
          if (pidx == 3 && idx == 0) begin
            frame = {cur, led_q};
            if (frame !== last) begin
              last = frame;
              if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: got %h expected no display change", frame);
              end else check("frame", frame, exp_q.pop_front());
            end
          end
          cur[idx*8 +: 8] = seg7;
          cur[(idx+4)*8 +: 8] = seg7_l;
          pidx = idx;
        end
        led_q = led;
      end
    end
  end
  initial begin
    logic found;
    logic [7:0] prev;
    repeat (3) @(negedge clk);
    check("rst_sel", {59'd0, seg7_sel}, 67'h11);
    check("rst_seg7", {59'd0, seg7}, 67'h0);
    check("rst_seg7_l", {59'd0, seg7_l}, 67'h0);
    check("rst_led", {64'd0, led}, 67'h0);
    repeat (200) @(negedge clk);
    check("rst_hold_sel", {59'd0, seg7_sel}, 67'h11);
    rst_n = 1'b0;
    expect_frame("1010    ", 3'b000);
    press(1'b1, 1'b0, 6);
    drain("g1_first_card");
    expect_frame("14 4    ", 3'b010);
    press(1'b1, 1'b0, 1);
    drain("g1_player_bust");
    press(1'b0, 1'b1, 1);
    expect_frame(" 9 9    ", 3'b000);
    press(1'b1, 1'b0, 1);
    drain("g2_first_card");
    expect_frame(" 9 9 2 2", 3'b000);
    expect_frame(" 9 9 6 4", 3'b000);
    expect_frame(" 9 914 8", 3'b001);
    press(1'b0, 1'b1, 1);
    drain("g2_dealer_bust");
    press(1'b1, 1'b0, 1);
    expect_frame(" 1 1    ", 3'b000);
    press(1'b1, 1'b0, 1);
    drain("g3_first_card");
    expect_frame(" 3 2    ", 3'b000);
    press(1'b1, 1'b1, 1);
    drain("g3_both_buttons_draw");
    expect_frame(" 8 5    ", 3'b000);
    press(1'b1, 1'b0, 1);
    drain("g3_third_card");
    expect_frame(" 8 51010", 3'b000);
    expect_frame(" 8 51010", 3'b010);
    press(1'b0, 1'b1, 1);
    drain("g3_dealer_stands");
    found = 1'b0;
    prev = seg7_sel;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      found = prev == 8'h11 && seg7_sel == 8'h22;
      prev = seg7_sel;
    end
    check("scan_sync", {66'd0, found}, 67'd1);
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check("scan_order", {59'd0, seg7_sel}, {59'd0, SCAN_SEQ[k]});
    end
    repeat (300) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1);
  end
endmodule
